// File: rtl/afe_spi_frame_receiver_if.sv
// AFE SPI lane bus: raw SPI lines and controls toward the receiver, decoded frame
// status back to the consumer.
interface afe_spi_frame_receiver_if #(
  parameter int unsigned WORD_WIDTH = 8
);
  logic                  enable;
  logic                  spiClk;
  logic                  spiSdi;
  logic                  spiLe;
  logic                  errClear;
  logic [WORD_WIDTH-1:0] rxData;
  logic                  rxValid;
  logic [15:0]           frameCount;
  logic [7:0]            bitCount;
  logic                  errLength;
  logic                  errTimeout;

  modport master (
    output enable, spiClk, spiSdi, spiLe, errClear,
    input  rxData, rxValid, frameCount, bitCount, errLength, errTimeout
  );

  modport slave (
    input  enable, spiClk, spiSdi, spiLe, errClear,
    output rxData, rxValid, frameCount, bitCount, errLength, errTimeout
  );
endinterface

// File: rtl/afe_spi_frame_receiver.sv
// Oversampling SPI frame receiver for one AFE attenuator lane: synchronizes the SPI
// lines into sysClk, deserializes MSB-first and validates frame length at LE rise.
module afe_spi_frame_receiver #(
  parameter int unsigned WORD_WIDTH   = 8,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned IDLE_TIMEOUT = 1023
) (
  input  logic                     sysClk,
  input  logic                     sysReset,
  afe_spi_frame_receiver_if.slave  bus
);

  localparam int unsigned TMR_W = (IDLE_TIMEOUT < 2) ? 1 : $clog2(IDLE_TIMEOUT + 1);
  localparam int unsigned CNT_W = 8;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync, sdi_sync, le_sync;
  logic                   clk_prev, le_prev;
  logic                   clk_rise_c, le_rise_c;
  logic                   clk_evt, sdi_evt, le_evt, le_evt2;
  logic [WORD_WIDTH-1:0]  shift_q, shift_d, rx_data_q, rx_data_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   err_len_q, err_len_d, err_to_q, err_to_d;

  assign clk_rise_c = clk_sync[SYNC_STAGES-1] & ~clk_prev;
  assign le_rise_c  = le_sync[SYNC_STAGES-1] & ~le_prev;

  // Synchronizers and edge events; LE gets one extra stage so a bit arriving in the
  // same cycle is already shifted in when the length is checked.
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      clk_sync <= '0;
      sdi_sync <= '0;
      le_sync  <= '0;
      clk_prev <= 1'b0;
      le_prev  <= 1'b0;
      clk_evt  <= 1'b0;
      sdi_evt  <= 1'b0;
      le_evt   <= 1'b0;
      le_evt2  <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], bus.spiClk};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], bus.spiSdi};
      le_sync  <= {le_sync[SYNC_STAGES-2:0], bus.spiLe};
      clk_prev <= clk_sync[SYNC_STAGES-1];
      le_prev  <= le_sync[SYNC_STAGES-1];
      clk_evt  <= bus.enable & clk_rise_c;
      sdi_evt  <= sdi_sync[SYNC_STAGES-1];
      le_evt   <= bus.enable & le_rise_c;
      le_evt2  <= bus.enable & le_evt;
    end
  end

  // State and datapath registers
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      tmr_q       <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_cnt_q <= '0;
      err_len_q   <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      tmr_q       <= tmr_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_cnt_q <= frame_cnt_d;
      err_len_q   <= err_len_d;
      err_to_q    <= err_to_d;
    end
  end

  // Next-state logic; a new error in the same cycle as errClear keeps the flag set
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    tmr_d       = tmr_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_len_d   = err_len_q & ~bus.errClear;
    err_to_d    = err_to_q & ~bus.errClear;

    if (!bus.enable) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      tmr_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          bit_cnt_d = '0;
          tmr_d     = '0;
          if (le_evt2) err_len_d = 1'b1;
          if (clk_evt) begin
            shift_d   = {shift_q[WORD_WIDTH-2:0], sdi_evt};
            bit_cnt_d = CNT_W'(1);
            state_d   = SHIFT;
          end
        end
        SHIFT: begin
          tmr_d = tmr_q + TMR_W'(1);
          if (le_evt2) begin
            if (bit_cnt_q == CNT_W'(WORD_WIDTH)) begin
              rx_data_d   = shift_q;
              rx_valid_d  = 1'b1;
              frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
              err_len_d = 1'b1;
            end
            bit_cnt_d = '0;
            tmr_d     = '0;
            state_d   = IDLE;
            // A clock edge that lands after LE opens the next frame
            if (clk_evt) begin
              shift_d   = {shift_q[WORD_WIDTH-2:0], sdi_evt};
              bit_cnt_d = CNT_W'(1);
              state_d   = SHIFT;
            end
          end else if (clk_evt) begin
            shift_d   = {shift_q[WORD_WIDTH-2:0], sdi_evt};
            bit_cnt_d = (bit_cnt_q == '1) ? bit_cnt_q : bit_cnt_q + CNT_W'(1);
            tmr_d     = '0;
          end else if (tmr_q == TMR_W'(IDLE_TIMEOUT)) begin
            err_to_d  = 1'b1;
            bit_cnt_d = '0;
            tmr_d     = '0;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.rxData     = rx_data_q;
  assign bus.rxValid    = rx_valid_q;
  assign bus.frameCount = frame_cnt_q;
  assign bus.bitCount   = bit_cnt_q;
  assign bus.errLength  = err_len_q;
  assign bus.errTimeout = err_to_q;

endmodule

// File: tb/tb_afe_spi_frame_receiver.sv
// Scoreboard bench for afe_spi_frame_receiver: directed SPI frames push expected words
// and strobe cycles; a negedge monitor pops and compares on every rxValid.
module tb_afe_spi_frame_receiver;
  localparam int unsigned WW = 8;
  localparam int unsigned SS = 2;
  localparam int unsigned TO = 1023;

  logic sysClk = 1'b0;
  logic sysReset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_data_q[$];
  int   exp_cyc_q[$];
  logic prev_valid = 1'b0;
  logic [15:0] exp_fc = 16'd0;

  afe_spi_frame_receiver_if #(.WORD_WIDTH(WW)) bus();

  afe_spi_frame_receiver #(.WORD_WIDTH(WW), .SYNC_STAGES(SS), .IDLE_TIMEOUT(TO)) dut (
    .sysClk(sysClk),
    .sysReset(sysReset),
    .bus(bus)
  );

  always #5 sysClk = ~sysClk;
  always @(posedge sysClk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest expectation, on time, for one cycle
  always @(negedge sysClk) begin
    if (!sysReset && bus.rxValid) begin
      check("strobe_single_cycle", {31'd0, prev_valid}, 32'd0);
      if (exp_data_q.size() == 0) begin
        check("unexpected_strobe", {24'd0, bus.rxData}, 32'hFFFF_FFFF);
      end else begin
        check("rx_data", {24'd0, bus.rxData}, 32'(exp_data_q.pop_front()));
        check("strobe_latency", 32'(cyc), 32'(exp_cyc_q.pop_front()));
      end
    end
    prev_valid = bus.rxValid;
  end

  task automatic waitc(input int n);
    repeat (n) @(posedge sysClk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.spiSdi = b;
    bus.spiClk = 1'b0;
    waitc(2);
    bus.spiClk = 1'b1;
    waitc(4);
    bus.spiClk = 1'b0;
    waitc(2);
  endtask

  task automatic send_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(val[i]);
  endtask

  // LE pulse; an accepted frame is expected SS+3 counter ticks after the drive point
  task automatic pulse_le(input logic accept, input logic [31:0] val);
    waitc(2);
    if (accept) begin
      exp_data_q.push_back(int'(val));
      exp_cyc_q.push_back(cyc + SS + 3);
      exp_fc = exp_fc + 16'd1;
    end
    bus.spiLe = 1'b1;
    waitc(4);
    bus.spiLe = 1'b0;
    waitc(SS + 6);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_data_q.size() != 0 && n < 60) begin
      waitc(1);
      n++;
    end
    check("scoreboard_drained", 32'(exp_data_q.size()), 32'd0);
  endtask

  task automatic send_frame(input logic [31:0] val, input int n, input logic accept);
    send_bits(val, n);
    pulse_le(accept, val);
    wait_drain();
  endtask

  initial begin
    bus.enable = 1'b1;
    bus.spiClk = 1'b0;
    bus.spiSdi = 1'b0;
    bus.spiLe = 1'b0;
    bus.errClear = 1'b0;
    waitc(3);
    sysReset = 1'b0;
    waitc(1);
    check("reset_rx_data", {24'd0, bus.rxData}, 32'd0);
    check("reset_rx_valid", {31'd0, bus.rxValid}, 32'd0);
    check("reset_frame_count", {16'd0, bus.frameCount}, 32'd0);
    check("reset_bit_count", {24'd0, bus.bitCount}, 32'd0);
    check("reset_err_length", {31'd0, bus.errLength}, 32'd0);
    check("reset_err_timeout", {31'd0, bus.errTimeout}, 32'd0);

    // Nominal frame
    send_frame(32'hA5, 8, 1'b1);
    check("nominal_frame_count", {16'd0, bus.frameCount}, {16'd0, exp_fc});
    check("nominal_err_length", {31'd0, bus.errLength}, 32'd0);
    check("nominal_err_timeout", {31'd0, bus.errTimeout}, 32'd0);
    check("nominal_bit_count", {24'd0, bus.bitCount}, 32'd0);

    // Short frame: error, no strobe, data held
    send_frame(32'h55, 7, 1'b0);
    check("short_err_length", {31'd0, bus.errLength}, 32'd1);
    check("short_rx_data_held", {24'd0, bus.rxData}, 32'hA5);
    check("short_frame_count", {16'd0, bus.frameCount}, {16'd0, exp_fc});
    bus.errClear = 1'b1;
    waitc(1);
    bus.errClear = 1'b0;
    check("err_clear", {31'd0, bus.errLength}, 32'd0);

    // Long frame: 1 then 0x5A
    send_frame(32'h15A, 9, 1'b0);
    check("long_err_length", {31'd0, bus.errLength}, 32'd1);
    check("long_rx_data_held", {24'd0, bus.rxData}, 32'hA5);

    // errClear coincident with a new length error: error wins
    send_bits(32'h3, 2);
    waitc(2);
    bus.spiLe = 1'b1;
    waitc(SS + 2);
    bus.errClear = 1'b1;
    waitc(1);
    bus.errClear = 1'b0;
    waitc(1);
    bus.spiLe = 1'b0;
    check("clear_vs_error", {31'd0, bus.errLength}, 32'd1);
    waitc(SS + 4);
    bus.errClear = 1'b1;
    waitc(1);
    bus.errClear = 1'b0;
    check("err_clear_again", {31'd0, bus.errLength}, 32'd0);

    // Zero-length frame from IDLE
    pulse_le(1'b0, 32'd0);
    check("zero_len_err", {31'd0, bus.errLength}, 32'd1);
    bus.errClear = 1'b1;
    waitc(1);
    bus.errClear = 1'b0;

    // Back-to-back frames
    send_frame(32'h00, 8, 1'b1);
    send_frame(32'hFF, 8, 1'b1);
    send_frame(32'h3C, 8, 1'b1);
    check("b2b_frame_count", {16'd0, bus.frameCount}, {16'd0, exp_fc});
    check("b2b_err_length", {31'd0, bus.errLength}, 32'd0);

    // Frame counter wrap
    force dut.frame_cnt_q = 16'hFFFF;
    waitc(1);
    release dut.frame_cnt_q;
    exp_fc = 16'hFFFF;
    send_frame(32'h11, 8, 1'b1);
    check("wrap_frame_count", {16'd0, bus.frameCount}, 32'd0);

    // Timeout after 3 bits
    send_bits(32'h5, 3);
    check("timeout_bits_seen", {24'd0, bus.bitCount}, 32'd3);
    waitc(TO - 30);
    check("timeout_not_yet", {31'd0, bus.errTimeout}, 32'd0);
    waitc(60);
    check("timeout_err", {31'd0, bus.errTimeout}, 32'd1);
    check("timeout_bit_count", {24'd0, bus.bitCount}, 32'd0);
    send_frame(32'h81, 8, 1'b1);
    check("after_timeout_err_length", {31'd0, bus.errLength}, 32'd0);
    bus.errClear = 1'b1;
    waitc(1);
    bus.errClear = 1'b0;
    check("timeout_cleared", {31'd0, bus.errTimeout}, 32'd0);

    // 8th clock rise and LE rise in the same cycle
    send_bits(32'h35, 7);
    bus.spiSdi = 1'b1;
    waitc(2);
    exp_data_q.push_back(32'h6B);
    exp_cyc_q.push_back(cyc + SS + 3);
    exp_fc = exp_fc + 16'd1;
    bus.spiClk = 1'b1;
    bus.spiLe = 1'b1;
    waitc(4);
    bus.spiClk = 1'b0;
    bus.spiLe = 1'b0;
    waitc(SS + 6);
    wait_drain();
    check("simul_err_length", {31'd0, bus.errLength}, 32'd0);
    check("simul_frame_count", {16'd0, bus.frameCount}, {16'd0, exp_fc});

    // enable low mid-frame
    send_bits(32'h9, 4);
    check("enable_bits_seen", {24'd0, bus.bitCount}, 32'd4);
    bus.enable = 1'b0;
    waitc(2);
    check("disable_bit_count", {24'd0, bus.bitCount}, 32'd0);
    send_bits(32'h6, 4);
    pulse_le(1'b0, 32'd0);
    check("disable_err_length", {31'd0, bus.errLength}, 32'd0);
    check("disable_frame_count", {16'd0, bus.frameCount}, {16'd0, exp_fc});
    check("disable_rx_data_held", {24'd0, bus.rxData}, 32'h6B);
    bus.enable = 1'b1;
    waitc(SS + 4);
    send_frame(32'h96, 8, 1'b1);
    check("reenable_frame_count", {16'd0, bus.frameCount}, {16'd0, exp_fc});

    // sysReset mid-frame
    send_bits(32'h1F, 5);
    sysReset = 1'b1;
    waitc(2);
    sysReset = 1'b0;
    waitc(1);
    exp_fc = 16'd0;
    check("midreset_rx_data", {24'd0, bus.rxData}, 32'd0);
    check("midreset_frame_count", {16'd0, bus.frameCount}, 32'd0);
    check("midreset_bit_count", {24'd0, bus.bitCount}, 32'd0);
    check("midreset_err_length", {31'd0, bus.errLength}, 32'd0);
    check("midreset_err_timeout", {31'd0, bus.errTimeout}, 32'd0);
    send_frame(32'h5C, 8, 1'b1);
    check("post_reset_frame_count", {16'd0, bus.frameCount}, 32'd1);
    check("post_reset_err_length", {31'd0, bus.errLength}, 32'd0);

    waitc(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
